// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: FSM state codes, pipeline control vector
// constants and the load-use detection helper used by the hazard unit.
package hazard_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_t;

    // NOP-control vector: every stage register loads a bubble and nothing advances.
    localparam ctrl_t CTRL_NOP      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_ADVANCE  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return mem_read && (rd != 5'd0) &&
               ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: ID/EX/MEM hazard sources in, pipeline enables and
// performance counters out.
interface hazard_control_unit_if #(parameter int CNT_W = 32);
    logic [4:0]       IF_ID_Rs1;
    logic [4:0]       IF_ID_Rs2;
    logic             ID_uses_rs1;
    logic             ID_uses_rs2;
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRd;
    logic             branch_taken_EX;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_write;
    logic             mem_wb_bubble;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output IF_ID_Rs1, IF_ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead,
               ID_EX_RegisterRd, branch_taken_EX, dmem_req, dmem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write,
               mem_wb_bubble, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  IF_ID_Rs1, IF_ID_Rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_MemRead,
               ID_EX_RegisterRd, branch_taken_EX, dmem_req, dmem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write,
               mem_wb_bubble, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;

    // Count register, frozen once it reaches all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= {CNT_W{1'b0}};
        end else if (inc && (q_q != {CNT_W{1'b1}})) begin
            q_q <= q_q + CNT_W'(1);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait
// FSM with sticky timeout, and saturating stall/flush counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    hazard_control_unit_if.slave  hz
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_hold_s;
    logic           load_use_s;
    ctrl_t          ctrl_s;

    assign mem_hold_s = (state_q == ST_ERROR) || (hz.dmem_req && !hz.dmem_ready);
    assign load_use_s = load_use_hit(hz.ID_EX_MemRead, hz.ID_EX_RegisterRd,
                                     hz.IF_ID_Rs1, hz.IF_ID_Rs2,
                                     hz.ID_uses_rs1, hz.ID_uses_rs2);

    // Memory-wait FSM next state; leaving MEM_WAIT on any non-hold cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_hold_s) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else begin
                    wait_cnt_d = {WCW{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_hold_s) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {WCW{1'b0}};
                end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
                    state_d = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = {WCW{1'b0}};
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= {WCW{1'b0}};
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Pipeline enables: reset > memory hold > branch > load-use > advance.
    always_comb begin
        if (rst) begin
            ctrl_s = CTRL_NOP;
        end else if (mem_hold_s) begin
            ctrl_s = CTRL_HOLD;
        end else if (hz.branch_taken_EX) begin
            ctrl_s = CTRL_FLUSH;
        end else if (load_use_s) begin
            ctrl_s = CTRL_LOAD_USE;
        end else begin
            ctrl_s = CTRL_ADVANCE;
        end
    end

    assign hz.pc_write      = ctrl_s.pc_write;
    assign hz.if_id_write   = ctrl_s.if_id_write;
    assign hz.if_id_flush   = ctrl_s.if_id_flush;
    assign hz.id_ex_bubble  = ctrl_s.id_ex_bubble;
    assign hz.ex_mem_write  = ctrl_s.ex_mem_write;
    assign hz.mem_wb_bubble = ctrl_s.mem_wb_bubble;
    assign hz.mem_timeout   = (state_q == ST_ERROR);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!rst && !ctrl_s.pc_write),
        .q   (hz.stall_cycles)
    );

    // A branch frozen behind a memory hold is counted once, when it finally flushes.
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (!rst && !mem_hold_s && hz.branch_taken_EX),
        .q   (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_hazard_control_unit;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vectors written {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}
    localparam logic [5:0] V_RESET   = 6'b001101;
    localparam logic [5:0] V_HOLD    = 6'b000001;
    localparam logic [5:0] V_FLUSH   = 6'b111110;
    localparam logic [5:0] V_LOADUSE = 6'b000110;
    localparam logic [5:0] V_ADVANCE = 6'b110010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit m_err   = 1'b0;
    int m_run   = 0;
    int m_stall = 0;
    int m_flush = 0;

    logic [5:0] dut_ctrl;
    logic [5:0] m_ctrl;
    logic       m_hold;

    assign dut_ctrl = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                       hz.id_ex_bubble, hz.ex_mem_write, hz.mem_wb_bubble};

    function automatic logic [5:0] model_ctrl(
        input logic r, input logic err, input logic req, input logic rdy,
        input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
        input logic [4:0] rs2, input logic u1, input logic u2, input logic br);
        int dep;
        dep = 0;
        if (mrd && rd != 5'd0) begin
            if (u1 && rd == rs1) dep = dep + 1;
            if (u2 && rd == rs2) dep = dep + 1;
        end
        if (r) return V_RESET;
        if (err || (req && !rdy)) return V_HOLD;
        if (br) return V_FLUSH;
        if (dep > 0) return V_LOADUSE;
        return V_ADVANCE;
    endfunction

    assign m_ctrl = model_ctrl(rst, m_err, hz.dmem_req, hz.dmem_ready, hz.ID_EX_MemRead,
                               hz.ID_EX_RegisterRd, hz.IF_ID_Rs1, hz.IF_ID_Rs2,
                               hz.ID_uses_rs1, hz.ID_uses_rs2, hz.branch_taken_EX);
    assign m_hold = m_err || (hz.dmem_req && !hz.dmem_ready);

    // Model update: error after more than MEM_TIMEOUT consecutive hold cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_err   <= 1'b0;
            m_run   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            if (!m_err) begin
                if (m_hold) begin
                    m_run <= m_run + 1;
                    if (m_run + 1 > MEM_TIMEOUT) m_err <= 1'b1;
                end else begin
                    m_run <= 0;
                end
            end
            if (m_ctrl == V_HOLD || m_ctrl == V_LOADUSE)
                m_stall <= (m_stall < CNT_MAX) ? m_stall + 1 : m_stall;
            if (m_ctrl == V_FLUSH)
                m_flush <= (m_flush < CNT_MAX) ? m_flush + 1 : m_flush;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_ctrl", 32'(dut_ctrl), 32'(m_ctrl));
            check("model_timeout", 32'(hz.mem_timeout), 32'(m_err));
            check("model_stall", 32'(hz.stall_cycles), 32'(m_stall));
            check("model_flush", 32'(hz.flush_count), 32'(m_flush));
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mrd, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic br, input logic req, input logic rdy);
        hz.ID_EX_MemRead    = mrd;
        hz.ID_EX_RegisterRd = rd;
        hz.IF_ID_Rs1        = rs1;
        hz.IF_ID_Rs2        = rs2;
        hz.ID_uses_rs1      = u1;
        hz.ID_uses_rs2      = u2;
        hz.branch_taken_EX  = br;
        hz.dmem_req         = req;
        hz.dmem_ready       = rdy;
    endtask

    task automatic idle();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        next_cyc();
        idle();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        next_cyc();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ctrl", 32'(dut_ctrl), 32'(V_RESET));
        check("reset_stall", 32'(hz.stall_cycles), 32'd0);
        check("reset_timeout", 32'(hz.mem_timeout), 32'd0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("idle_advance", 32'(dut_ctrl), 32'(V_ADVANCE));

        // lw x5 in EX, ID reads x5 through rs2
        next_cyc();
        set_in(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("loaduse_stall", 32'(dut_ctrl), 32'(V_LOADUSE));
        next_cyc();
        idle();
        @(negedge clk);
        check("loaduse_after", 32'(dut_ctrl), 32'(V_ADVANCE));
        check("loaduse_stall_cnt", 32'(hz.stall_cycles), 32'd1);

        next_cyc();
        set_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rd_zero_no_stall", 32'(dut_ctrl), 32'(V_ADVANCE));
        next_cyc();
        set_in(1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("unused_rs1_no_stall", 32'(dut_ctrl), 32'(V_ADVANCE));

        // Load-use coincident with a taken branch: the flush wins
        next_cyc();
        set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("branch_over_loaduse", 32'(dut_ctrl), 32'(V_FLUSH));
        next_cyc();
        idle();
        @(negedge clk);
        check("branch_flush_cnt", 32'(hz.flush_count), 32'd1);
        check("branch_stall_cnt", 32'(hz.stall_cycles), 32'd1);

        // Three memory wait cycles then ready
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cyc();
            @(negedge clk);
            check("memwait_hold", 32'(dut_ctrl), 32'(V_HOLD));
        end
        next_cyc();
        hz.dmem_ready = 1'b1;
        @(negedge clk);
        check("memwait_ready", 32'(dut_ctrl), 32'(V_ADVANCE));
        next_cyc();
        idle();
        @(negedge clk);
        check("memwait_stall_cnt", 32'(hz.stall_cycles), 32'd3);
        check("memwait_no_timeout", 32'(hz.mem_timeout), 32'd0);

        // Memory never ready: timeout then asynchronous reset recovery
        do_reset();
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            if (i > 0) next_cyc();
            @(negedge clk);
            check("timeout_pending", 32'(hz.mem_timeout), 32'd0);
        end
        next_cyc();
        @(negedge clk);
        check("timeout_set", 32'(hz.mem_timeout), 32'd1);
        next_cyc();
        hz.dmem_req = 1'b0;
        @(negedge clk);
        check("error_holds", 32'(dut_ctrl), 32'(V_HOLD));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_timeout", 32'(hz.mem_timeout), 32'd0);
        check("async_rst_ctrl", 32'(dut_ctrl), 32'(V_RESET));
        check("async_rst_stall", 32'(hz.stall_cycles), 32'd0);
        next_cyc();
        rst = 1'b0;

        // Saturation of the stall counter
        do_reset();
        set_in(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) next_cyc();
        idle();
        @(negedge clk);
        check("stall_saturate", 32'(hz.stall_cycles), 32'(CNT_MAX));

        // Randomized run with occasional asynchronous resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            next_cyc();
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst = 1'b1;
                next_cyc();
                rst = 1'b0;
            end
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 2) != 0));
        end
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage RV32 core. It detects load-use hazards and taken-branch redirects, and drives the stall, flush and bubble enables consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also owns the variable-latency data-memory wait FSM with a timeout error, plus saturating stall and flush performance counters. Operand bypassing stays in the forwarding logic; this block decides only when the pipeline may advance.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before error (≥2).
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- IF_ID_Rs1, IF_ID_Rs2  in  5  source registers of the instruction in ID.
- ID_uses_rs1, ID_uses_rs2  in  1  the ID instruction actually reads that source.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- ID_EX_RegisterRd  in  5  destination register of the EX instruction.
- branch_taken_EX  in  1  branch/jump in EX resolved taken this cycle.
- dmem_req  in  1  MEM stage has an active load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID register may load.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads a NOP (control bits zeroed).
- ex_mem_write  out  1  ID/EX and EX/MEM registers may load.
- mem_wb_bubble  out  1  MEM/WB loads a NOP.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_count  out  CNT_W  count of taken-branch flushes.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR.
- mem_hold = dmem_req & ~dmem_ready in RUN or MEM_WAIT; forced to 1 in ERROR.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRd≠0) & ((ID_uses_rs1 & Rd==IF_ID_Rs1) | (ID_uses_rs2 & Rd==IF_ID_Rs2)).
- Outputs are combinational from state and inputs. Priority order: mem_hold > branch > load_use.
  - mem_hold: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1, if_id_flush=0, id_ex_bubble=0.
  - branch_taken_EX (no hold): pc_write=1, if_id_flush=1, id_ex_bubble=1. A coincident load-use is ignored because the dependent instruction is wrong-path.
  - load_use (no hold, no branch): pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1.
  - Otherwise: pc_write=if_id_write=ex_mem_write=1 and all bubbles/flushes=0.
- Transitions:
  - RUN→MEM_WAIT when mem_hold; wait_cnt←1.
  - MEM_WAIT→RUN when dmem_ready; otherwise wait_cnt++.
  - MEM_WAIT→ERROR when wait_cnt==MEM_TIMEOUT and ~dmem_ready.
  - ERROR is held until rst.
- mem_timeout=1 exactly when the state is ERROR.
- A branch held during MEM_WAIT stays asserted because EX is frozen. Its flush applies, and flush_count increments once, on the first non-hold cycle.
- Counters saturate at all-ones and never wrap.
  - stall_cycles increments each non-reset cycle with pc_write=0.
  - flush_count increments each cycle where the branch flush is applied.

## Timing
- Stall and flush outputs have zero latency (same cycle as the cause); pipeline registers act on the following edge.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM, load_use deasserts, and the forwarding logic supplies the operand.
- Memory wait of N cycles (dmem_ready high on the (N+1)th cycle of dmem_req): N hold cycles; the pipe advances at the edge ending the ready cycle.
- In the dmem_ready cycle, outputs follow the non-hold rules even while in MEM_WAIT.
- While rst is high, and at reset release:
  - pc_write=0, if_id_write=0, ex_mem_write=0.
  - if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
  - State=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
- Reset mid-MEM_WAIT or in ERROR returns the block to RUN immediately (asynchronous).

## Structure
- Shared package hazard_pkg holds the state enum (RUN, MEM_WAIT, ERROR) and the NOP-control constant. It is shared with the pipeline register modules.
- One sub-module, sat_counter (CNT_W, inc, clk, rst → q), is instantiated twice, for stall_cycles and flush_count.

## Test plan
- EX is lw x5 with ID_EX_RegisterRd=5; ID has IF_ID_Rs2=5 and ID_uses_rs2=1 → one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle is all-advance; stall_cycles=1.
- Load with Rd=0 matching Rs1=0, or a match where ID_uses_rs1=0 → no stall.
- load_use and branch_taken_EX in the same cycle → if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count=1; stall_cycles unchanged.
- dmem_req=1 with dmem_ready low for 3 cycles then high → 3 hold cycles with mem_wb_bubble=1, state returns to RUN, stall_cycles=3.
- MEM_TIMEOUT=4, dmem_ready never rises → ERROR after 4 wait cycles, mem_timeout=1 and holds persist; asserting rst asynchronously clears everything to reset values.
- Preload a counter to all-ones via a long stall (CNT_W=4, 20 stall cycles) → stall_cycles holds at 15.
